// File: rtl/dot_product_sequencer.sv
// Dot-product sequencer: walks a shared address across operand memories A and B,
// then drives the multiply-accumulate controls in step with the returning read data.
module dot_product_sequencer #(
  parameter int ADDR_WIDTH = 3,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  output logic                  acc_clr,
  output logic                  mac_en,
  output logic                  mac_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [RD_LATENCY-1:0] en_pipe;
  logic [RD_LATENCY-1:0] last_pipe;
  logic                  addr_is_last;

  // The address is one bit narrower than len_q, so it is zero-extended before
  // comparing; this lets a full 2^ADDR_WIDTH job stop at the top address without wrapping.
  assign addr_is_last = ({1'b0, addr_q} == (len_q - ONE));
  assign rd_addr      = addr_q;
  assign mac_en       = en_pipe[RD_LATENCY-1];
  assign mac_last     = last_pipe[RD_LATENCY-1];

  // State register; the job length is captured (and saturated) only on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        len_q <= (len > MAX_LEN) ? MAX_LEN : len;
      end
    end
  end

  // Read address counter: steps through the vector while fetching, otherwise parked at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else if (state_q == FETCH && !addr_is_last) begin
      addr_q <= addr_q + 1'b1;
    end else begin
      addr_q <= '0;
    end
  end

  // Delay line that re-times the read strobe and last-element flag to the data arrival.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_pipe   <= '0;
      last_pipe <= '0;
    end else begin
      en_pipe[0]   <= rd_en;
      last_pipe[0] <= rd_en & addr_is_last;
      for (int i = 1; i < RD_LATENCY; i++) begin
        en_pipe[i]   <= en_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    acc_clr = 1'b0;
    done    = 1'b0;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
        acc_clr = 1'b1;
        state_d = (len_q == '0) ? DONE : FETCH;
      end
      FETCH: begin
        rd_en = 1'b1;
        if (addr_is_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (mac_last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/dot_product_sequencer.md
DOT_PRODUCT_SEQUENCER -- requirements
Module: dot_product_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 3, SHALL set the vector-memory address width; maximum vector length is 2^ADDR_WIDTH.
REQ-002 Parameter RD_LATENCY, default 1, legal range 1..4, SHALL set the cycles from rd_en to valid read data.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  level sampled each edge; begins a job when sampled high in IDLE.
REQ-006 len  input  ADDR_WIDTH+1  element count, captured only on the accepted start edge.
REQ-007 rd_addr  output  ADDR_WIDTH  shared read address for operand memories A and B.
REQ-008 rd_en  output  1  read strobe for both memories.
REQ-009 acc_clr  output  1  one-cycle accumulator clear.
REQ-010 mac_en  output  1  multiply-accumulate enable, aligned with valid read data.
REQ-011 mac_last  output  1  high together with the final mac_en of a job.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle completion pulse.

Function
REQ-014 States SHALL be IDLE, CLEAR, FETCH, DRAIN, DONE, in that order.
REQ-015 IDLE -> CLEAR on an edge with start=1; len SHALL be latched as len_q.
- len_q SHALL saturate to 2^ADDR_WIDTH when len exceeds it.
REQ-016 CLEAR SHALL last exactly one cycle, with acc_clr=1 and rd_addr=0.
- Next state: DONE if len_q=0, else FETCH.
REQ-017 FETCH SHALL last exactly len_q cycles, with rd_en=1.
- rd_addr SHALL take 0,1,...,len_q-1 on consecutive cycles.
- Address wrap at 2^ADDR_WIDTH SHALL never be issued.
REQ-018 After the cycle carrying address len_q-1, the state SHALL go to DRAIN.
REQ-019 mac_en SHALL equal rd_en delayed by exactly RD_LATENCY cycles, via a shift register.
- mac_last SHALL equal "rd_en and address = len_q-1", delayed by the same RD_LATENCY cycles.
REQ-020 DRAIN SHALL exit to DONE on the edge after the cycle in which mac_last=1.
REQ-021 DONE SHALL last one cycle with done=1, then return to IDLE.
- A start high during DONE SHALL be ignored.
- A new job requires start sampled in IDLE.
REQ-022 start SHALL be ignored in every state other than IDLE; len changes while busy SHALL have no effect.
REQ-023 Outside the states and cycles above, rd_en, acc_clr, mac_en, mac_last and done SHALL be 0, and rd_addr SHALL hold 0.
REQ-024 Timing, taking the start-accept edge as E0:
- acc_clr is high after E0.
- The first rd_en is high after E1.
- The final mac_en is high after E(len_q+RD_LATENCY).
- done is high after E(len_q+RD_LATENCY+1).
- For len_q=0, done is high after E1, with no rd_en and no mac_en.
REQ-025 The number of mac_en pulses per job SHALL equal len_q exactly.

Reset
REQ-026 With rst=1 at an edge, the state SHALL go to IDLE and len_q and the delay line SHALL clear.
- All outputs SHALL be 0 after that edge, including rd_addr=0 and busy=0.
REQ-027 rst SHALL have priority over start on the same edge.
REQ-028 A reset mid-job SHALL suppress all in-flight mac_en/mac_last pulses and SHALL produce no done pulse.

Verification
REQ-029 len=4, RD_LATENCY=1, start pulse at E0 -> acc_clr after E0; rd_addr 0..3 with rd_en after E1..E4; mac_en after E2..E5; mac_last after E5; done after E6; busy high after E0..E6.
REQ-030 len=0 -> acc_clr after E0, done after E1, zero rd_en/mac_en pulses, then IDLE.
REQ-031 len=15, ADDR_WIDTH=3 -> saturates to 8; rd_addr 0..7; exactly 8 mac_en pulses; done after E10 (RD_LATENCY=1).
REQ-032 RD_LATENCY=3, len=2 -> rd_en after E1..E2; mac_en after E4..E5; done after E6.
REQ-033 start held high continuously with len=3 (RD_LATENCY=1) -> back-to-back jobs; second acc_clr one cycle after the first done's IDLE cycle; no start accepted while busy.
REQ-034 rst=1 asserted at E3 of a len=8 job -> all outputs 0 after E3, no later mac_en or done; a fresh start after rst is released runs a full, correct job.
